// File: rtl/hop_reset_sequencer_if.sv
// Handshake and chain-side signals between the hop reset sequencer and its user.
// The master modport is the bench/wrapper side; the slave modport is the sequencer.
interface hop_reset_sequencer_if #(
    parameter int NUM_STAGES = 3
) ();
    logic                  go;
    logic                  chain_out;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [7:0]            latency;

    modport master (
        output go,
        output chain_out,
        input  stage_rst,
        input  start,
        input  busy,
        input  done,
        input  pass,
        input  latency
    );

    modport slave (
        input  go,
        input  chain_out,
        output stage_rst,
        output start,
        output busy,
        output done,
        output pass,
        output latency
    );
endinterface

// File: rtl/hop_reset_sequencer.sv
// Reset sequencer and latency meter for a hop flip-flop chain under test.
// Optional build macro HOP_SEQ_REVERSE_EN releases stage resets from the highest index down.
module hop_reset_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int GAP_CYCLES = 4,
    parameter int EXP_LAT    = 4,
    parameter int TIMEOUT    = 16
) (
    input logic             clock0,
    input logic             rst1,
    hop_reset_sequencer_if.slave bus
);
    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PH_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0]      GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TO_C     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]      EXP_C    = CNT_W'(EXP_LAT);
    localparam logic [PH_W-1:0]       PH_LAST  = PH_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_RST  = {NUM_STAGES{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_LAUNCH  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [PH_W-1:0]       ph_r, ph_s;
    logic                  early_r, early_s;
    logic [NUM_STAGES-1:0] stage_rst_r, stage_rst_s;
    logic                  start_r, start_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  pass_r, pass_s;
    logic [7:0]            latency_r, latency_s;

    // Release phase ph maps to a stage index; the reverse build walks from the top down.
    function automatic logic [NUM_STAGES-1:0] clear_stage(
        input logic [NUM_STAGES-1:0] vec,
        input logic [PH_W-1:0]       ph
    );
        logic [PH_W-1:0]       idx;
        logic [NUM_STAGES-1:0] res;
`ifdef HOP_SEQ_REVERSE_EN
        idx = PH_LAST - ph;
`else
        idx = ph;
`endif
        for (int i = 0; i < NUM_STAGES; i++) begin
            res[i] = (PH_W'(i) == idx) ? 1'b0 : vec[i];
        end
        return res;
    endfunction

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ph_s        = ph_r;
        early_s     = early_r;
        stage_rst_s = stage_rst_r;
        pass_s      = pass_r;
        latency_s   = latency_r;
        start_s     = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.go) begin
                    state_s     = ST_HOLD;
                    cnt_s       = '0;
                    stage_rst_s = ALL_RST;
                    busy_s      = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                busy_s      = 1'b1;
                stage_rst_s = ALL_RST;
                if (cnt_r == GAP_LAST) begin
                    state_s     = ST_RELEASE;
                    cnt_s       = '0;
                    ph_s        = '0;
                    stage_rst_s = clear_stage(ALL_RST, PH_W'(0));
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                busy_s = 1'b1;
                if (cnt_r == GAP_LAST) begin
                    cnt_s = '0;
                    if (ph_r == PH_LAST) begin
                        state_s = ST_LAUNCH;
                        start_s = 1'b1;
                    end else begin
                        ph_s        = ph_r + PH_W'(1);
                        stage_rst_s = clear_stage(stage_rst_r, ph_r + PH_W'(1));
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_LAUNCH: begin
                // cnt_r is 0 here; chain_out already high at launch marks the run as early.
                busy_s  = 1'b1;
                early_s = bus.chain_out;
                cnt_s   = CNT_W'(1);
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.chain_out) begin
                    latency_s = 8'(cnt_r);
                    pass_s    = (cnt_r == EXP_C) && !early_r;
                    done_s    = 1'b1;
                    state_s   = ST_DONE;
                end else if (cnt_r == TO_C) begin
                    latency_s = 8'(TO_C);
                    pass_s    = 1'b0;
                    done_s    = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    busy_s = 1'b1;
                    cnt_s  = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = '0;
                ph_s        = '0;
                stage_rst_s = ALL_RST;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clock0) begin
        if (rst1) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            ph_r        <= '0;
            early_r     <= 1'b0;
            stage_rst_r <= ALL_RST;
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            latency_r   <= 8'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ph_r        <= ph_s;
            early_r     <= early_s;
            stage_rst_r <= stage_rst_s;
            start_r     <= start_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            latency_r   <= latency_s;
        end
    end

    assign bus.stage_rst = stage_rst_r;
    assign bus.start     = start_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.latency   = latency_r;
endmodule

// File: tb/tb_hop_reset_sequencer.sv
// Scoreboard bench for hop_reset_sequencer: expected events are queued per run, monitors pop and compare.
module tb_hop_reset_sequencer;
    logic clock0;
    logic rst1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   go_cyc = 0;
    int   mode = 0;
    bit   mon_en = 1'b0;
    logic [2:0] prev_stage = 3'b111;
    logic [4:1] ff;

    typedef struct { logic [2:0] val; int off; } stage_exp_t;
    typedef struct { logic pass; int lat; int off; } done_exp_t;
    stage_exp_t stage_q[$];
    int         start_q[$];
    done_exp_t  done_q[$];

`ifdef HOP_SEQ_REVERSE_EN
    localparam logic [2:0] S1 = 3'b011;
    localparam logic [2:0] S2 = 3'b001;
`else
    localparam logic [2:0] S1 = 3'b110;
    localparam logic [2:0] S2 = 3'b100;
`endif

    hop_reset_sequencer_if #(.NUM_STAGES(3)) bus ();

    hop_reset_sequencer #(
        .NUM_STAGES(3), .GAP_CYCLES(4), .EXP_LAT(4), .TIMEOUT(16)
    ) dut (
        .clock0(clock0),
        .rst1  (rst1),
        .bus   (bus.slave)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;
    always @(posedge clock0) cyc <= cyc + 1;

    // four-flop chain: ff1 on rst1, ff2..ff4 on stage_rst[0..2]
    always @(posedge clock0) begin
        ff[1] <= rst1 ? 1'b0 : bus.start;
        ff[2] <= bus.stage_rst[0] ? 1'b0 : ff[1];
        ff[3] <= bus.stage_rst[1] ? 1'b0 : ff[2];
        ff[4] <= bus.stage_rst[2] ? 1'b0 : ff[3];
    end
    assign bus.chain_out = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ff[4];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clock0) begin
        if (mon_en && bus.stage_rst !== prev_stage) begin
            checks++;
            if (stage_q.size() == 0) begin
                errors++;
                $display("FAIL stage_rst: unexpected change to %b at offset %0d", bus.stage_rst, cyc - go_cyc);
            end else begin
                stage_exp_t e;
                e = stage_q.pop_front();
                if (bus.stage_rst !== e.val || (cyc - go_cyc) != e.off) begin
                    errors++;
                    $display("FAIL stage_rst: got %b at offset %0d expected %b at offset %0d",
                             bus.stage_rst, cyc - go_cyc, e.val, e.off);
                end
            end
            prev_stage = bus.stage_rst;
        end
    end

    always @(negedge clock0) begin
        if (mon_en && bus.start === 1'b1) begin
            checks++;
            if (start_q.size() == 0) begin
                errors++;
                $display("FAIL start: unexpected pulse at offset %0d", cyc - go_cyc);
            end else begin
                int o;
                o = start_q.pop_front();
                if ((cyc - go_cyc) != o) begin
                    errors++;
                    $display("FAIL start: got offset %0d expected %0d", cyc - go_cyc, o);
                end
            end
        end
    end

    always @(negedge clock0) begin
        if (mon_en && bus.done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done: unexpected pulse at offset %0d", cyc - go_cyc);
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                if (bus.pass !== d.pass || int'(bus.latency) != d.lat ||
                    (cyc - go_cyc) != d.off || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done: got pass=%b lat=%0d off=%0d busy=%b expected pass=%b lat=%0d off=%0d busy=0",
                             bus.pass, bus.latency, cyc - go_cyc, bus.busy, d.pass, d.lat, d.off);
                end
            end
        end
    end

    task automatic wait_off(input int n);
        while ((cyc - go_cyc) < n) @(negedge clock0);
    endtask

    task automatic wait_clear(input int budget);
        int n;
        n = 0;
        while ((stage_q.size() + start_q.size() + done_q.size()) != 0 && n < budget) begin
            @(negedge clock0);
            n++;
        end
        checks++;
        if ((stage_q.size() + start_q.size() + done_q.size()) != 0) begin
            errors++;
            $display("FAIL timeout: %0d stage, %0d start, %0d done events still pending",
                     stage_q.size(), start_q.size(), done_q.size());
            stage_q.delete();
            start_q.delete();
            done_q.delete();
        end
    endtask

    // m: 0 real chain, 1 chain_out tied 0, 2 tied 1; rst_at>0 asserts rst1 at that offset
    task automatic do_run(input int m, input bit released, input bit exp_pass, input int lat,
                          input bit repulse, input int rst_at);
        mode = m;
        @(negedge clock0);
        if (released) stage_q.push_back('{3'b111, 1});
        stage_q.push_back('{S1, 5});
        stage_q.push_back('{S2, 9});
        stage_q.push_back('{3'b000, 13});
        start_q.push_back(17);
        if (rst_at > 0) stage_q.push_back('{3'b111, rst_at + 1});
        else done_q.push_back('{exp_pass, lat, 18 + lat});
        bus.go = 1'b1;
        go_cyc = cyc;
        @(negedge clock0);
        bus.go = 1'b0;
        if (repulse) begin
            wait_off(8);
            bus.go = 1'b1;
            @(negedge clock0);
            bus.go = 1'b0;
        end
        if (rst_at > 0) begin
            wait_off(rst_at);
            rst1 = 1'b1;
            @(negedge clock0);
            rst1 = 1'b0;
            chk("midrun_rst busy", int'(bus.busy), 0);
            chk("midrun_rst done", int'(bus.done), 0);
            chk("midrun_rst start", int'(bus.start), 0);
            chk("midrun_rst latency", int'(bus.latency), 0);
            repeat (25) @(negedge clock0);
        end
        wait_clear(60);
        repeat (2) @(negedge clock0);
    endtask

    initial begin
        rst1 = 1'b1;
        bus.go = 1'b0;
        mode = 0;
        repeat (2) @(posedge clock0);
        @(negedge clock0);
        chk("reset stage_rst", int'(bus.stage_rst), 7);
        chk("reset start", int'(bus.start), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset pass", int'(bus.pass), 0);
        chk("reset latency", int'(bus.latency), 0);
        rst1 = 1'b0;
        prev_stage = 3'b111;
        mon_en = 1'b1;

        do_run(0, 1'b0, 1'b1, 4, 1'b1, 0);
        chk("hold pass", int'(bus.pass), 1);
        chk("hold latency", int'(bus.latency), 4);
        chk("idle stage_rst released", int'(bus.stage_rst), 0);
        do_run(1, 1'b1, 1'b0, 16, 1'b0, 0);
        do_run(2, 1'b1, 1'b0, 1, 1'b1, 0);
        do_run(1, 1'b1, 1'b0, 0, 1'b0, 20);
        do_run(0, 1'b0, 1'b1, 4, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
